icache: RTL and testbench

Direct-mapped instruction cache between the fetch stage and the instruction memory bus. It performs a combinational lookup of the fetch address and returns the instruction word in the same cycle on a hit. On a miss it asserts `miss` so the hazard unit stalls fetch, then refills the whole line from memory with a burst handshake. Fetch sees `Instr1_fIM` and `miss` directly; the memory side sees one outstanding line request at a time.

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_refill_fsm.sv | 54 +++++
 rtl/icache.sv | 69 ++++++
 tb/tb_icache.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, width helpers and the NOP word for the icache.
package icache_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;
  localparam logic [31:0] NOP = 32'h0;
  function automatic int word_w(input int words);
    return $clog2(words);
  endfunction
  function automatic int offset_w(input int words);
    return $clog2(words) + 2;
  endfunction
  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int lines, input int words);
    return 32 - offset_w(words) - index_w(lines);
  endfunction
endpackage

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: line refill sequencer; latches the missing line, counts
// burst beats and raises write-enables for the data, tag and valid arrays.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [31:0]                         addr,
  input  logic                                lookup_hit,
  input  logic                                flush,
  input  logic                                mem_rvalid,
  output state_t                              state,
  output logic                                mem_req,
  output logic [31:0]                         mem_addr,
  output logic [index_w(NUM_LINES)-1:0]       fill_index,
  output logic [word_w(WORDS_PER_LINE)-1:0]   beat,
  output logic                                start,
  output logic                                data_we,
  output logic                                tag_we,
  output logic                                valid_set
);
  localparam int WORD_W   = word_w(WORDS_PER_LINE);
  localparam int OFFSET_W = offset_w(WORDS_PER_LINE);
  localparam int INDEX_W  = index_w(NUM_LINES);
  localparam logic [WORD_W-1:0] LAST = WORD_W'(WORDS_PER_LINE - 1);
  state_t next;
  logic   flush_pend;
  always_ff @(posedge CLK)
    if (!RESET) begin
      state      <= IDLE;
      beat       <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= next;
      if (start) begin
        mem_addr   <= addr & ~32'(WORDS_PER_LINE * 4 - 1);
        fill_index <= addr[OFFSET_W +: INDEX_W];
        beat       <= '0;
      end else if (data_we) beat <= beat + WORD_W'(1);
      flush_pend <= (state == DONE) ? 1'b0 : (flush && state == REFILL) ? 1'b1 : flush_pend;
    end
  // A flush landing in DONE itself must also keep the in-flight line invalid.
  always_comb begin
    mem_req   = state == REFILL;
    start     = state == IDLE && !lookup_hit;
    data_we   = mem_req && mem_rvalid;
    tag_we    = state == DONE;
    valid_set = tag_we && !flush_pend && !flush;
    next      = start ? REFILL : (data_we && beat == LAST) ? DONE : tag_we ? IDLE : state;
  end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache with combinational hit path and burst line refill.
// Optional perf counters hit_count/miss_count are built when ICACHE_PERF_EN is defined.
module icache
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr_address_2IM,
  input  logic        STALL,
  input  logic        flush,
  output logic [31:0] Instr1_fIM,
  output logic        miss,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int WORD_W   = word_w(WORDS_PER_LINE);
  localparam int OFFSET_W = offset_w(WORDS_PER_LINE);
  localparam int INDEX_W  = index_w(NUM_LINES);
  localparam int TAG_W    = tag_w(NUM_LINES, WORDS_PER_LINE);
  logic [31:0]        data_arr [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]   tag_arr  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  state_t             state;
  logic [INDEX_W-1:0] index, fill_index;
  logic [WORD_W-1:0]  word, beat;
  logic               lookup_hit, hit, start, data_we, tag_we, valid_set, unused;
  assign index      = Instr_address_2IM[OFFSET_W +: INDEX_W];
  assign word       = Instr_address_2IM[2 +: WORD_W];
  assign lookup_hit = valid[index] && tag_arr[index] == Instr_address_2IM[31 -: TAG_W];
  assign hit        = lookup_hit && state == IDLE;
  assign miss       = !hit;
  assign Instr1_fIM = hit ? data_arr[index][word] : NOP;
  icache_refill_fsm #(.NUM_LINES(NUM_LINES), .WORDS_PER_LINE(WORDS_PER_LINE)) u_fsm (
    .CLK(CLK), .RESET(RESET), .addr(Instr_address_2IM), .lookup_hit(lookup_hit),
    .flush(flush), .mem_rvalid(mem_rvalid), .state(state), .mem_req(mem_req),
    .mem_addr(mem_addr), .fill_index(fill_index), .beat(beat), .start(start),
    .data_we(data_we), .tag_we(tag_we), .valid_set(valid_set)
  );
  always_ff @(posedge CLK) begin
    if (data_we) data_arr[fill_index][beat] <= mem_rdata;
    if (tag_we) tag_arr[fill_index] <= mem_addr[31 -: TAG_W];
  end
  always_ff @(posedge CLK)
    if (!RESET || flush) valid <= '0;
    else if (valid_set) valid[fill_index] <= 1'b1;
`ifdef ICACHE_PERF_EN
  always_ff @(posedge CLK)
    if (!RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && !STALL) hit_count <= hit_count + 32'd1;
      if (start) miss_count <= miss_count + 32'd1;
    end
  assign unused = ^Instr_address_2IM[1:0];
`else
  assign unused = ^{STALL, Instr_address_2IM[1:0]};
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scoreboard bench; stimulus queues expected hit words and refill
// addresses, a negedge monitor pops them as the cache presents hits and new requests.
module tb_icache;
  logic        CLK = 1'b0, RESET = 1'b0, STALL = 1'b0, flush = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] addr = 32'h0, mem_rdata = 32'h0;
  logic [31:0] Instr1_fIM, mem_addr;
  logic        miss, mem_req;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif
  int          n_tests = 0, n_fail = 0;
  logic [31:0] hitq[$], reqq[$];
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  icache dut (
`ifdef ICACHE_PERF_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .CLK(CLK), .RESET(RESET), .Instr_address_2IM(addr), .STALL(STALL), .flush(flush),
    .Instr1_fIM(Instr1_fIM), .miss(miss), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (miss) chk("nop_on_miss", Instr1_fIM, 32'h0);
    else if (hitq.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL unexpected_hit: addr %h instr %h", addr, Instr1_fIM);
    end else chk("hit_data", Instr1_fIM, hitq.pop_front());
    if (mem_req && !prev_req) begin
      if (reqq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_req: mem_addr %h", mem_addr);
      end else chk("req_addr", mem_addr, reqq.pop_front());
    end
    if (mem_req && prev_req) chk("mem_addr_stable", mem_addr, prev_addr);
    prev_req  = mem_req;
    prev_addr = mem_addr;
  end

  // One slot: drive the address, queue what the cache must produce for it, advance one cycle.
  task automatic step(input logic [31:0] a, input bit h, input logic [31:0] d);
    if (h) hitq.push_back(d); else reqq.push_back(d);
    addr = a;
    @(posedge CLK); #1;
  endtask

  // Called in the DONE cycle: covers DONE plus the first IDLE lookup.
  task automatic after_fill(input logic [31:0] a, input bit h, input logic [31:0] d);
    if (h) hitq.push_back(d); else reqq.push_back(d);
    addr = a;
    @(posedge CLK); @(posedge CLK); #1;
  endtask

  task automatic do_refill(input logic [31:0] w0, w1, w2, w3, input int gap, input logic [31:0] mid);
    logic [31:0] w [4];
    int k;
    w = '{w0, w1, w2, w3};
    k = 0;
    while (!mem_req && k < 10) begin
      @(posedge CLK); #1;
      k++;
    end
    if (!mem_req) begin
      n_tests++; n_fail++;
      $display("FAIL refill_timeout: mem_req %b after %0d cycles", mem_req, k);
    end
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin @(posedge CLK); #1; end
      mem_rvalid = 1'b1;
      mem_rdata  = w[i];
      if (i == 1) addr = mid;
      @(posedge CLK); #1;
      mem_rvalid = 1'b0;
    end
  endtask

  initial begin
    addr = 32'hBFC00000;
    repeat (3) @(posedge CLK);
    #1;
    reqq.push_back(32'hBFC00000);
    RESET = 1'b1;
    chk("reset_miss", 32'(miss), 32'd1);
    chk("reset_instr", Instr1_fIM, 32'h0);
    chk("reset_req", 32'(mem_req), 32'd0);
`ifdef ICACHE_PERF_EN
    chk("reset_hit_count", hit_count, 32'd0);
`endif
    do_refill(32'h11, 32'h22, 32'h33, 32'h44, 0, 32'hBFC00000);
    after_fill(32'hBFC00008, 1, 32'h33);
`ifdef ICACHE_PERF_EN
    chk("miss_count_1", miss_count, 32'd1);
    chk("hit_count_1", hit_count, 32'd1);
`endif
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    step(32'hBFC00004, 1, 32'h22);
    mem_rvalid = 1'b0;
    STALL = 1'b1;
    step(32'hBFC0000C, 1, 32'h44);
    STALL = 1'b0;
    step(32'hBFC00000, 1, 32'h11);
`ifdef ICACHE_PERF_EN
    chk("hit_count_stall", hit_count, 32'd3);
`endif
    step(32'hBFC00400, 0, 32'hBFC00400);
    do_refill(32'hA1, 32'hA2, 32'hA3, 32'hA4, 0, 32'hBFC00400);
    after_fill(32'hBFC00404, 1, 32'hA2);
    step(32'hBFC00000, 0, 32'hBFC00000);
    do_refill(32'h11, 32'h22, 32'h33, 32'h44, 2, 32'h00400000);
    after_fill(32'hBFC00008, 1, 32'h33);
    step(32'h00400000, 0, 32'h00400000);
    do_refill(32'h55, 32'h66, 32'h77, 32'h88, 0, 32'h00400000);
    after_fill(32'h0040000C, 1, 32'h88);
    flush = 1'b1;
    step(32'h00400004, 1, 32'h66);
    flush = 1'b0;
    step(32'h00400004, 0, 32'h00400000);
    do_refill(32'h55, 32'h66, 32'h77, 32'h88, 0, 32'h00400004);
    after_fill(32'h00400008, 1, 32'h77);
    step(32'h00001010, 0, 32'h00001010);
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    do_refill(32'hC1, 32'hC2, 32'hC3, 32'hC4, 0, 32'h00001010);
    after_fill(32'h00001010, 0, 32'h00001010);
    do_refill(32'hD1, 32'hD2, 32'hD3, 32'hD4, 0, 32'h00001010);
    after_fill(32'h00001014, 1, 32'hD2);
    step(32'h00400000, 0, 32'h00400000);
    do_refill(32'h55, 32'h66, 32'h77, 32'h88, 0, 32'h00400000);
    after_fill(32'h00400004, 1, 32'h66);
    step(32'hBFC00020, 0, 32'hBFC00020);
    mem_rvalid = 1'b1; mem_rdata = 32'hE1;
    @(posedge CLK); #1;
    mem_rdata = 32'hE2;
    @(posedge CLK); #1;
    mem_rvalid = 1'b0;
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("rst_burst_req", 32'(mem_req), 32'd0);
    chk("rst_burst_miss", 32'(miss), 32'd1);
    reqq.push_back(32'h00001010);
    addr  = 32'h00001014;
    RESET = 1'b1;
    chk("rst_line_invalid", 32'(miss), 32'd1);
    do_refill(32'hF1, 32'hF2, 32'hF3, 32'hF4, 0, 32'h00001014);
    after_fill(32'h00001018, 1, 32'hF3);
`ifdef ICACHE_PERF_EN
    chk("miss_count_end", miss_count, 32'd1);
    chk("hit_count_end", hit_count, 32'd1);
`endif
    chk("hitq_drained", 32'(hitq.size()), 32'd0);
    chk("reqq_drained", 32'(reqq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
